// File: rtl/ahb_sram_slave.sv
// AHB-Lite data-memory slave: wait-state insertion, byte/halfword/word lane writes, two-cycle ERROR.
// Optional write protection below WP_LIMIT is built when AHB_SRAM_WP_EN is defined.
module ahb_sram_slave #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_STATES = 1,
  parameter logic [31:0] WP_LIMIT    = 32'h100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hsel,
  input  logic [31:0] haddr,
  input  logic [1:0]  htrans,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [31:0] hwdata,
  input  logic        hready_in,
  output logic [31:0] hrdata,
  output logic        hreadyout,
  output logic        hresp
);

  localparam int unsigned AW         = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int unsigned CW         = 3;
  localparam logic [31:0] BYTE_LIMIT = 32'(4 * DEPTH_WORDS);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } state_t;

  state_t        state;
  logic [AW-1:0] addr_q;
  logic          write_q;
  logic [3:0]    lanes_q;
  logic [CW-1:0] wait_cnt;

  logic [31:0]   mem [DEPTH_WORDS];

  logic          accept_c;
  logic          err_c;
  logic          wp_err_c;
  logic          commit_c;
  logic [3:0]    lanes_c;
  logic [AW-1:0] rd_idx_c;
  logic [31:0]   rd_word_c;
  logic          unused_bits;

  // Only NONSEQ/SEQ matter; htrans[0] carries no information for this slave.
  assign unused_bits = ^{htrans[0], WP_LIMIT};

  assign accept_c = hsel & hready_in & htrans[1] & hreadyout;

`ifdef AHB_SRAM_WP_EN
  assign wp_err_c = hwrite & (haddr < WP_LIMIT);
`else
  assign wp_err_c = 1'b0;
`endif

  assign err_c = (hsize > 3'b010)
               | ((hsize == 3'b001) & haddr[0])
               | ((hsize == 3'b010) & (haddr[1:0] != 2'b00))
               | (haddr >= BYTE_LIMIT)
               | wp_err_c;

  // Byte-lane enables for the transfer presented in the address phase.
  always_comb begin
    lanes_c = 4'b0000;
    case (hsize)
      3'b000:  lanes_c = 4'(4'b0001 << haddr[1:0]);
      3'b001:  lanes_c = haddr[1] ? 4'b1100 : 4'b0011;
      3'b010:  lanes_c = 4'b1111;
      default: lanes_c = 4'b0000;
    endcase
  end

  assign commit_c = (state == ST_DATA) & write_q & ~reset;

  // The read lands in the same edge that commits a pending write, so forward the new bytes.
  assign rd_idx_c = (state == ST_WAIT) ? addr_q : haddr[AW+1:2];

  always_comb begin
    rd_word_c = mem[rd_idx_c];
    for (int i = 0; i < 4; i++) begin
      if (commit_c && lanes_q[i] && (addr_q == rd_idx_c)) begin
        rd_word_c[8*i +: 8] = hwdata[8*i +: 8];
      end
    end
  end

  // Array write; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (commit_c) begin
      for (int i = 0; i < 4; i++) begin
        if (lanes_q[i]) begin
          mem[addr_q][8*i +: 8] <= hwdata[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      hreadyout <= 1'b1;
      hresp     <= 1'b0;
      hrdata    <= 32'h0;
      addr_q    <= '0;
      write_q   <= 1'b0;
      lanes_q   <= 4'b0000;
      wait_cnt  <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DATA, ST_ERR2: begin
          if (accept_c) begin
            addr_q  <= haddr[AW+1:2];
            write_q <= hwrite;
            lanes_q <= lanes_c;
            if (err_c) begin
              state     <= ST_ERR1;
              hreadyout <= 1'b0;
              hresp     <= 1'b1;
            end else if (WAIT_STATES == 0) begin
              state     <= ST_DATA;
              hreadyout <= 1'b1;
              hresp     <= 1'b0;
              if (!hwrite) begin
                hrdata <= rd_word_c;
              end
            end else begin
              state     <= ST_WAIT;
              hreadyout <= 1'b0;
              hresp     <= 1'b0;
              wait_cnt  <= CW'(WAIT_STATES - 1);
            end
          end else begin
            state     <= ST_IDLE;
            hreadyout <= 1'b1;
            hresp     <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (wait_cnt == '0) begin
            state     <= ST_DATA;
            hreadyout <= 1'b1;
            hresp     <= 1'b0;
            if (!write_q) begin
              hrdata <= rd_word_c;
            end
          end else begin
            wait_cnt <= wait_cnt - CW'(1);
          end
        end
        ST_ERR1: begin
          state     <= ST_ERR2;
          hreadyout <= 1'b1;
          hresp     <= 1'b1;
        end
        default: begin
          state     <= ST_IDLE;
          hreadyout <= 1'b1;
          hresp     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Directed bench for ahb_sram_slave: one instance with one wait state, one with none.
module tb_ahb_sram_slave;

  logic        clk = 1'b0;
  logic        reset;
  logic        hsel0, hsel1;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [31:0] hwdata;
  logic [31:0] hrdata0, hrdata1;
  logic        rdy0, rdy1, resp0, resp1;
  logic        dut_sel;
  int          checks;
  int          errors;

  ahb_sram_slave #(.DEPTH_WORDS(1024), .WAIT_STATES(1), .WP_LIMIT(32'h100)) dut_ws1 (
    .clk(clk), .reset(reset), .hsel(hsel0), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata), .hready_in(rdy0),
    .hrdata(hrdata0), .hreadyout(rdy0), .hresp(resp0));

  ahb_sram_slave #(.DEPTH_WORDS(1024), .WAIT_STATES(0), .WP_LIMIT(32'h100)) dut_ws0 (
    .clk(clk), .reset(reset), .hsel(hsel1), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata), .hready_in(rdy1),
    .hrdata(hrdata1), .hreadyout(rdy1), .hresp(resp1));

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic cur_rdy();
    return dut_sel ? rdy1 : rdy0;
  endfunction

  function automatic logic cur_resp();
    return dut_sel ? resp1 : resp0;
  endfunction

  function automatic logic [31:0] cur_rdata();
    return dut_sel ? hrdata1 : hrdata0;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One non-pipelined transfer; returns the first and last data-phase samples.
  task automatic ahb_xfer(input logic wr, input logic [2:0] size, input logic [31:0] addr,
                          input logic [31:0] wdata, output logic [31:0] rdata,
                          output logic first_rdy, output logic first_resp,
                          output logic resp, output int cycles);
    @(negedge clk);
    if (dut_sel) hsel1 = 1'b1; else hsel0 = 1'b1;
    htrans = 2'b10; hwrite = wr; hsize = size; haddr = addr;
    @(negedge clk);
    hsel0 = 1'b0; hsel1 = 1'b0; htrans = 2'b00; hwdata = wdata;
    cycles = 1;
    first_rdy  = cur_rdy();
    first_resp = cur_resp();
    while (cur_rdy() !== 1'b1 && cycles < 16) begin
      @(negedge clk);
      cycles++;
    end
    check("xfer_done", 32'(cur_rdy()), 32'd1);
    rdata = cur_rdata();
    resp  = cur_resp();
  endtask

  task automatic do_write(input string tag, input logic [2:0] size, input logic [31:0] addr,
                          input logic [31:0] wdata);
    logic [31:0] rd; logic fr, fp, rp; int cyc;
    ahb_xfer(1'b1, size, addr, wdata, rd, fr, fp, rp, cyc);
    check({tag, "_first_rdy"}, 32'(fr), dut_sel ? 32'd1 : 32'd0);
    check({tag, "_resp"}, 32'(rp), 32'd0);
    check({tag, "_cycles"}, 32'(cyc), dut_sel ? 32'd1 : 32'd2);
  endtask

  task automatic do_read(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] rd; logic fr, fp, rp; int cyc;
    ahb_xfer(1'b0, 3'b010, addr, 32'h0, rd, fr, fp, rp, cyc);
    check({tag, "_data"}, rd, exp);
    check({tag, "_resp"}, 32'(rp), 32'd0);
    check({tag, "_cycles"}, 32'(cyc), dut_sel ? 32'd1 : 32'd2);
  endtask

  task automatic do_err(input string tag, input logic wr, input logic [2:0] size,
                        input logic [31:0] addr);
    logic [31:0] rd; logic fr, fp, rp; int cyc;
    ahb_xfer(wr, size, addr, 32'hFFFF_FFFF, rd, fr, fp, rp, cyc);
    check({tag, "_err1_rdy"}, 32'(fr), 32'd0);
    check({tag, "_err1_resp"}, 32'(fp), 32'd1);
    check({tag, "_err2_resp"}, 32'(rp), 32'd1);
    check({tag, "_cycles"}, 32'(cyc), 32'd2);
  endtask

  // Write then read of the same word issued back-to-back on the zero-wait instance.
  task automatic pipe_wr_rd(input string tag, input logic [2:0] size, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [31:0] exp);
    @(negedge clk);
    hsel1 = 1'b1; htrans = 2'b10; hwrite = 1'b1; hsize = size; haddr = addr;
    @(negedge clk);
    check({tag, "_wr_nostall"}, 32'(rdy1), 32'd1);
    hwdata = wdata; hwrite = 1'b0; hsize = 3'b010; haddr = {addr[31:2], 2'b00};
    @(negedge clk);
    hsel1 = 1'b0; htrans = 2'b00;
    check({tag, "_rd_rdy"}, 32'(rdy1), 32'd1);
    check({tag, "_rd_resp"}, 32'(resp1), 32'd0);
    check({tag, "_rd_data"}, hrdata1, exp);
  endtask

  initial begin
    checks = 0; errors = 0; dut_sel = 1'b0;
    reset = 1'b1; hsel0 = 1'b0; hsel1 = 1'b0; haddr = 32'h0; htrans = 2'b00;
    hwrite = 1'b0; hsize = 3'b010; hwdata = 32'h0;
    repeat (3) @(negedge clk);
    check("reset_rdy", 32'(rdy0), 32'd1);
    check("reset_resp", 32'(resp0), 32'd0);
    check("reset_rdata", hrdata0, 32'h0);
    reset = 1'b0;

    // Basic word write/read with one wait state
    do_write("t1_wr", 3'b010, 32'h40, 32'hDEAD_BEEF);
    do_read("t1_rd", 32'h40, 32'hDEAD_BEEF);

    // Byte and halfword lane merges
    do_write("t2_wr_word", 3'b010, 32'h40, 32'h1122_3344);
    do_write("t2_wr_b3", 3'b000, 32'h43, 32'hAA00_0000);
    do_read("t2_rd_b3", 32'h40, 32'hAA22_3344);
    do_write("t2_wr_h0", 3'b001, 32'h40, 32'h0000_5566);
    do_read("t2_rd_h0", 32'h40, 32'hAA22_5566);
    do_write("t2_wr_h1", 3'b001, 32'h42, 32'h7788_0000);
    do_write("t2_wr_b1", 3'b000, 32'h41, 32'h0000_BB00);
    do_read("t2_rd_mix", 32'h40, 32'h7788_BB66);

    // Error responses leave memory untouched
    do_err("t3_misword_rd", 1'b0, 3'b010, 32'h42);
    do_err("t3_misword_wr", 1'b1, 3'b010, 32'h42);
    do_err("t3_mishalf_wr", 1'b1, 3'b001, 32'h41);
    do_err("t3_badsize_wr", 1'b1, 3'b011, 32'h40);
    do_read("t3_unchanged", 32'h40, 32'h7788_BB66);
    do_err("t3_oor_rd", 1'b0, 3'b010, 32'h1000);
    do_err("t3_oor_wr", 1'b1, 3'b000, 32'h1000);
    do_write("t3_last_wr", 3'b010, 32'hFFC, 32'h0BAD_F00D);
    do_read("t3_last_rd", 32'hFFC, 32'h0BAD_F00D);

    // IDLE and BUSY while selected: zero-wait OKAY
    @(negedge clk);
    hsel0 = 1'b1; htrans = 2'b00; hwrite = 1'b1; haddr = 32'h40;
    @(negedge clk);
    check("idle_rdy", 32'(rdy0), 32'd1);
    check("idle_resp", 32'(resp0), 32'd0);
    htrans = 2'b01;
    @(negedge clk);
    hsel0 = 1'b0; htrans = 2'b00;
    check("busy_rdy", 32'(rdy0), 32'd1);
    check("busy_resp", 32'(resp0), 32'd0);
    do_read("idle_nowrite", 32'h40, 32'h7788_BB66);

    // Reset in the middle of a write wait state
    do_write("t5_clear", 3'b010, 32'h20, 32'h0);
    @(negedge clk);
    hsel0 = 1'b1; htrans = 2'b10; hwrite = 1'b1; hsize = 3'b010; haddr = 32'h20;
    @(negedge clk);
    hsel0 = 1'b0; htrans = 2'b00; hwdata = 32'h1234_5678;
    check("t5_in_wait", 32'(rdy0), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("t5_rst_rdy", 32'(rdy0), 32'd1);
    check("t5_rst_resp", 32'(resp0), 32'd0);
    check("t5_rst_rdata", hrdata0, 32'h0);
    do_read("t5_rd", 32'h20, 32'h0);

    // Zero wait states, pipelined read-after-write
    dut_sel = 1'b1;
    pipe_wr_rd("t4_word", 3'b010, 32'h80, 32'hCAFE_F00D, 32'hCAFE_F00D);
    do_read("t4_rd", 32'h80, 32'hCAFE_F00D);
    do_write("t4_wr84", 3'b010, 32'h84, 32'h0102_0304);
    pipe_wr_rd("t4_byte", 3'b000, 32'h85, 32'h0000_EE00, 32'h0102_EE04);
    do_err("t4_err", 1'b0, 3'b001, 32'h87);

    // Write-protection region
    dut_sel = 1'b0;
`ifdef AHB_SRAM_WP_EN
    do_err("t6_wp_wr", 1'b1, 3'b010, 32'h10);
    begin
      logic [31:0] rd; logic fr, fp, rp; int cyc;
      ahb_xfer(1'b0, 3'b010, 32'h10, 32'h0, rd, fr, fp, rp, cyc);
      check("t6_wp_rd_resp", 32'(rp), 32'd0);
      check("t6_wp_rd_notwritten", 32'(rd == 32'hFFFF_FFFF), 32'd0);
    end
`else
    do_write("t6_low_wr", 3'b010, 32'h10, 32'h5A5A_A5A5);
    do_read("t6_low_rd", 32'h10, 32'h5A5A_A5A5);
`endif
    do_write("t6_wr100", 3'b010, 32'h100, 32'h600D_0100);
    do_read("t6_rd100", 32'h100, 32'h600D_0100);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ahb_sram_slave.md
Name: ahb_sram_slave

Overview:
AHB-Lite data-memory slave that sits downstream of the slave-side glue and address decoder. It replaces the bare RAM behind the data-memory select with a protocol-correct slave. The block captures address-phase controls, inserts a configurable number of wait states and performs byte/halfword/word writes with lane enables. It returns full 32-bit read words; the master glue extracts lanes and applies sign extension. It drives hreadyout/hresp back into the response mux.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words in the array; valid byte range is 0 to 4*DEPTH_WORDS-1 (offset from slave base).
WAIT_STATES, 1, data-phase wait cycles inserted per OKAY NONSEQ/SEQ transfer (0..7).
WP_LIMIT, 32'h100, byte offset below which writes are rejected when the optional feature is compiled in.

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high reset
hsel  input  1  slave select from decoder
haddr  input  32  byte address (slave-relative offset)
htrans  input  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11
hwrite  input  1  1=write, 0=read
hsize  input  3  000 byte, 001 halfword, 010 word
hwdata  input  32  write data, valid in data phase
hready_in  input  1  bus-wide HREADY; address phase is accepted only when high
hrdata  output  32  read data, valid when hreadyout=1 at end of read data phase
hreadyout  output  1  slave ready
hresp  output  1  0=OKAY, 1=ERROR

Behaviour:
- Reset (reset=1 at clk edge): state IDLE, hreadyout=1, hresp=0, hrdata=0, captured controls cleared, wait counter cleared. Array contents are not reset. Reset during WAIT or ERR abandons the transfer, and a pending write is not committed.
- Address phase accepted when hsel & hready_in & htrans[1]. The block registers haddr, hwrite and hsize. IDLE/BUSY transfers, or hsel=0, give a zero-wait OKAY and leave memory untouched.
- Error check at acceptance. Any one of the following causes an ERROR:
  - hsize>010;
  - halfword with haddr[0]=1;
  - word with haddr[1:0]!=00;
  - haddr >= 4*DEPTH_WORDS.
- States:
  - IDLE: hreadyout=1, hresp=0. On a valid accept, go to WAIT if WAIT_STATES>0, else go to DATA behaviour in the next cycle. On an erroneous accept, go to ERR1.
  - WAIT: hreadyout=0, hresp=0. Counter counts WAIT_STATES cycles, then go to DATA.
  - DATA (final data-phase cycle): hreadyout=1, hresp=0. A write commits hwdata at the closing edge. A new transfer can be accepted in this same cycle (pipelined back-to-back).
  - ERR1: hreadyout=0, hresp=1. Always go to ERR2.
  - ERR2: hreadyout=1, hresp=1. A new transfer may be accepted; no memory change occurs.
- Byte lanes for writes:
  - byte: lane haddr[1:0] only;
  - halfword: lanes {haddr[1],0} and {haddr[1],1};
  - word: all four lanes.
  - Unselected bytes are preserved. Data is taken from the matching hwdata lanes (little-endian).
- Reads: hrdata = full word at haddr[31:2], valid in the cycle hreadyout=1. Outside read data phases, hrdata holds its last value.
- Latency:
  - OKAY transfer: WAIT_STATES+1 data-phase cycles.
  - ERROR: 2 data-phase cycles.
- Read-after-write to the same word, back-to-back (even with WAIT_STATES=0), must return the newly written bytes. Provide a forwarding path if the array read precedes the commit.
- Simultaneous accept and data phase is legal only in DATA and ERR2 states. In every state, the next transfer's address phase is ignored while hreadyout=0.

Optional Feature:
Macro AHB_SRAM_WP_EN.
- Defined: a write accepted with haddr < WP_LIMIT takes the ERROR path (ERR1/ERR2) and does not modify the array. Reads of that region stay OKAY.
- Not defined: WP_LIMIT is unused and all in-range aligned writes are OKAY.

Test Plan:
1. Reset, then word write of 32'hDEADBEEF to 0x40 followed by a word read of 0x40, WAIT_STATES=1 -> write: hreadyout 0 then 1, hresp=0; read: hrdata=32'hDEADBEEF.
2. Byte write of 8'hAA to 0x43 over word 32'h11223344 -> read 0x40 returns 32'hAA223344. Halfword write of 16'h5566 to 0x40 -> read returns 32'hAA225566.
3. Word read at 0x42 -> hreadyout=0/hresp=1, then hreadyout=1/hresp=1, and memory is unchanged. Read at 0x1000 with DEPTH_WORDS=1024 -> same two-cycle ERROR.
4. WAIT_STATES=0: back-to-back write 32'hCAFEF00D to 0x80 then read 0x80 on the next cycle -> hrdata=32'hCAFEF00D with no stall.
5. Assert reset mid-WAIT of a write of 32'h12345678 to 0x20 (prior content 32'h0) -> outputs return to their reset values and a read of 0x20 returns 32'h0.
6. With AHB_SRAM_WP_EN defined, a word write to 0x10 -> two-cycle ERROR and a read of 0x10 shows old data. A write to 0x100 -> OKAY.
